pipelined_acc_nch: RTL

PIPELINED_ACC_NCH -- requirements
Module: pipelined_acc_nch

---
 rtl/pipelined_acc_nch.sv | 117 +++++++++++
 1 files changed

// File: rtl/pipelined_acc_nch.sv
// ============================================================================
// Module      : pipelined_acc_nch
// Description : N-channel W-bit accumulator (A += I), adder split into two
//               H-bit pipeline stages; INIT loads A/I, STEP emits result.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_acc_nch #(
  parameter int W = 32,
  parameter int N = 4,
  localparam int CW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_vld,
  input  logic          cmd_init,
  input  logic [CW-1:0] cmd_ch,
  input  logic [W-1:0]  a_init,
  input  logic [W-1:0]  i,
  output logic          y_vld,
  output logic [CW-1:0] y_ch,
  output logic [W-1:0]  y,
  output logic          y_ovf
);

  localparam int H = W / 2;
  localparam logic [CW:0] C_N = (CW+1)'(N);

  // Per-channel state, kept as separate halves so each stage touches one half.
  logic [H-1:0] a_lo_q [N];
  logic [H-1:0] a_hi_q [N];
  logic [H-1:0] i_lo_q [N];
  logic [H-1:0] i_hi_q [N];

  logic          p_vld_q;
  logic          p_init_q;
  logic [CW-1:0] p_ch_q;
  logic [H-1:0]  p_hi_q;
  logic [H-1:0]  p_lo_q;
  logic          p_cy_q;

  logic          y_vld_q;
  logic [CW-1:0] y_ch_q;
  logic [W-1:0]  y_q;
  logic          y_ovf_q;

  logic          cmd_ok;
  logic [H:0]    lo_sum;
  logic [H:0]    hi_sum;

  assign cmd_ok = cmd_vld && ({1'b0, cmd_ch} < C_N);
  assign lo_sum = {1'b0, a_lo_q[cmd_ch]} + {1'b0, i_lo_q[cmd_ch]};
  assign hi_sum = {1'b0, a_hi_q[p_ch_q]} + {1'b0, p_hi_q} + {{H{1'b0}}, p_cy_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < N; c++) begin
        a_lo_q[c] <= '0;
        a_hi_q[c] <= '0;
        i_lo_q[c] <= '0;
        i_hi_q[c] <= '0;
      end
      p_vld_q  <= 1'b0;
      p_init_q <= 1'b0;
      p_ch_q   <= '0;
      p_hi_q   <= '0;
      p_lo_q   <= '0;
      p_cy_q   <= 1'b0;
      y_vld_q  <= 1'b0;
      y_ch_q   <= '0;
      y_q      <= '0;
      y_ovf_q  <= 1'b0;
    end else begin
      // Stage 1: low half of the add, or low half + whole increment for INIT.
      p_vld_q <= cmd_ok;
      if (cmd_ok) begin
        p_init_q <= cmd_init;
        p_ch_q   <= cmd_ch;
        if (cmd_init) begin
          a_lo_q[cmd_ch] <= a_init[H-1:0];
          i_lo_q[cmd_ch] <= i[H-1:0];
          i_hi_q[cmd_ch] <= i[W-1:H];
          p_hi_q         <= a_init[W-1:H];
          p_lo_q         <= a_init[H-1:0];
          p_cy_q         <= 1'b0;
        end else begin
          a_lo_q[cmd_ch] <= lo_sum[H-1:0];
          p_hi_q         <= i_hi_q[cmd_ch];
          p_lo_q         <= lo_sum[H-1:0];
          p_cy_q         <= lo_sum[H];
        end
      end

      // Stage 2: high half; p_hi_q is I_hi for STEP and a_init_hi for INIT.
      y_vld_q <= p_vld_q && !p_init_q;
      if (p_vld_q) begin
        if (p_init_q) begin
          a_hi_q[p_ch_q] <= p_hi_q;
        end else begin
          a_hi_q[p_ch_q] <= hi_sum[H-1:0];
          y_q            <= {hi_sum[H-1:0], p_lo_q};
          y_ch_q         <= p_ch_q;
          y_ovf_q        <= hi_sum[H];
        end
      end
    end
  end

  assign y_vld = y_vld_q;
  assign y_ch  = y_ch_q;
  assign y     = y_q;
  assign y_ovf = y_ovf_q;

endmodule

`default_nettype wire
